// File: rtl/uart_rx_axis.sv
// uart_rx_axis
// Receives 8N1 serial frames on an asynchronous rx line and presents each good byte
// on an AXI-Stream master port through a one-entry holding register.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   rx             in   asynchronous serial input, idle high
//   m_axis_tdata   out  received byte
//   m_axis_tvalid  out  tdata holds an unconsumed byte
//   m_axis_tready  in   downstream accepts when tvalid && tready
//   frame_err      out  one-cycle pulse, stop bit sampled low
//   overrun        out  one-cycle pulse, byte completed while holding register full
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | timing to the start-bit centre; rx_s high there is a glitch
// DATA  | sampling 8 data bits at bit centres, LSB first
// STOP  | sampling the stop bit
// BRK   | stop bit was low; waiting for the line to return high
module uart_rx_axis #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int BIT_CNT  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam logic [15:0] BIT_LAST  = 16'(BIT_CNT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [2:0]  idx, idx_d;
    logic [7:0]  shreg, shreg_d;
    logic        done, done_d;
    logic        ferr_d;
    logic        rx_m, rx_s;

    // Two-flop synchronizer; reset to the idle line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            idx       <= 3'd0;
            shreg     <= 8'h00;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            shreg     <= shreg_d;
            done      <= done_d;
            frame_err <= ferr_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 16'd1;
        idx_d   = idx;
        shreg_d = shreg;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = 16'd0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_d   = 16'd0;
                    idx_d   = 3'd0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_d        = 16'd0;
                    shreg_d[idx] = rx_s;
                    idx_d        = idx + 3'd1;
                    if (idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_d = 16'd0;
                    if (rx_s) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BRK;
                    end
                end
            end
            BRK: begin
                cnt_d = 16'd0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Holding register. shreg is stable from the stop sample until the next
    // frame's first data bit, so it can be loaded directly on done.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!m_axis_tvalid || m_axis_tready) begin
                    m_axis_tdata  <= shreg;
                    m_axis_tvalid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_axis.sv
// tb_uart_rx_axis
// Directed bench for uart_rx_axis at 50 MHz / 115200 baud (434 clocks per bit).
// Inputs are driven 1 time unit after a rising edge; a negedge monitor records
// accepted bytes and pulse counts, which the stimulus compares against fixed values.
module tb_uart_rx_axis;

    localparam int BIT_CNT = 434;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready = 1'b1;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int tv_cnt = 0;
    int rise_cyc = 0;
    logic tv_prev = 1'b0;
    logic [7:0] got_q[$];

    uart_rx_axis #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .frame_err     (frame_err),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tvalid && tready) got_q.push_back(tdata);
        if (tvalid) tv_cnt++;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (tvalid && !tv_prev) rise_cyc = cyc;
        tv_prev = tvalid;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(BIT_CNT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BIT_CNT);
        end
        rx = stop_bit;
        tick(BIT_CNT);
        rx = 1'b1;
    endtask

    int qb, feb, ovb, tvb, c0, lat;

    initial begin
        tick(5);
        check_val("rst_tdata", {24'd0, tdata}, 32'h00);
        check_val("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check_val("rst_ferr", {31'd0, frame_err}, 32'd0);
        check_val("rst_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        tick(20);

        // 1: single byte, tready high
        qb = got_q.size(); feb = fe_cnt; ovb = ov_cnt; tvb = tv_cnt;
        c0 = cyc;
        send_byte(8'hA5, 1'b1);
        tick(30);
        lat = rise_cyc - c0;
        check_val("t1_nbytes", got_q.size() - qb, 1);
        if (got_q.size() > qb) check_val("t1_data", {24'd0, got_q[qb]}, 32'hA5);
        check_val("t1_tv_width", tv_cnt - tvb, 1);
        check_val("t1_latency_ok", {31'd0, (lat >= 4124 && lat <= 4130)}, 32'd1);
        check_val("t1_ferr", fe_cnt - feb, 0);
        check_val("t1_ovr", ov_cnt - ovb, 0);

        // 2: short glitch rejected, then a real byte
        qb = got_q.size(); feb = fe_cnt;
        rx = 1'b0;
        tick(100);
        rx = 1'b1;
        tick(400);
        check_val("t2_glitch_nbytes", got_q.size() - qb, 0);
        check_val("t2_glitch_ferr", fe_cnt - feb, 0);
        send_byte(8'h3C, 1'b1);
        tick(30);
        check_val("t2_nbytes", got_q.size() - qb, 1);
        if (got_q.size() > qb) check_val("t2_data", {24'd0, got_q[qb]}, 32'h3C);

        // 3: bad stop bit followed by a long break
        qb = got_q.size(); feb = fe_cnt; ovb = ov_cnt;
        send_byte(8'h3C, 1'b0);
        rx = 1'b0;
        tick(2000);
        rx = 1'b1;
        tick(100);
        check_val("t3_ferr_once", fe_cnt - feb, 1);
        check_val("t3_nbytes", got_q.size() - qb, 0);
        check_val("t3_ovr", ov_cnt - ovb, 0);
        send_byte(8'h81, 1'b1);
        tick(30);
        check_val("t3_after_nbytes", got_q.size() - qb, 1);
        if (got_q.size() > qb) check_val("t3_after_data", {24'd0, got_q[qb]}, 32'h81);
        check_val("t3_after_ferr", fe_cnt - feb, 1);

        // 4: backpressure and overrun
        qb = got_q.size(); feb = fe_cnt; ovb = ov_cnt;
        tready = 1'b0;
        send_byte(8'h11, 1'b1);
        tick(20);
        check_val("t4_hold_tvalid", {31'd0, tvalid}, 32'd1);
        check_val("t4_hold_tdata", {24'd0, tdata}, 32'h11);
        check_val("t4_ovr_none_yet", ov_cnt - ovb, 0);
        send_byte(8'h22, 1'b1);
        tick(20);
        check_val("t4_ovr", ov_cnt - ovb, 1);
        check_val("t4_keep_tdata", {24'd0, tdata}, 32'h11);
        check_val("t4_keep_tvalid", {31'd0, tvalid}, 32'd1);
        check_val("t4_ferr", fe_cnt - feb, 0);
        tready = 1'b1;
        tick(2);
        check_val("t4_drained_tvalid", {31'd0, tvalid}, 32'd0);
        check_val("t4_nbytes", got_q.size() - qb, 1);
        if (got_q.size() > qb) check_val("t4_data", {24'd0, got_q[qb]}, 32'h11);
        tick(20);

        // 5: reset in the middle of 8'hF0 (after 4 data bits)
        qb = got_q.size();
        rx = 1'b0;
        tick(BIT_CNT);
        for (int i = 0; i < 4; i++) tick(BIT_CNT);
        rst = 1'b1;
        tick(3);
        check_val("t5_rst_tdata", {24'd0, tdata}, 32'h00);
        check_val("t5_rst_tvalid", {31'd0, tvalid}, 32'd0);
        check_val("t5_rst_ferr", {31'd0, frame_err}, 32'd0);
        check_val("t5_rst_ovr", {31'd0, overrun}, 32'd0);
        rx = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(BIT_CNT * 6);
        check_val("t5_no_byte", got_q.size() - qb, 0);
        send_byte(8'h5A, 1'b1);
        tick(30);
        check_val("t5_nbytes", got_q.size() - qb, 1);
        if (got_q.size() > qb) check_val("t5_data", {24'd0, got_q[qb]}, 32'h5A);

        // 6: back-to-back frames with no idle gap
        qb = got_q.size(); feb = fe_cnt; ovb = ov_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        tick(30);
        check_val("t6_nbytes", got_q.size() - qb, 2);
        if (got_q.size() > qb + 1) begin
            check_val("t6_data0", {24'd0, got_q[qb]}, 32'h00);
            check_val("t6_data1", {24'd0, got_q[qb+1]}, 32'hFF);
        end
        check_val("t6_ferr", fe_cnt - feb, 0);
        check_val("t6_ovr", ov_cnt - ovb, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
